// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and helpers.
// Round counts are derived from NK so that no block can be configured inconsistently.
package aes_pkg;

    localparam int AES_WORD_W = 32;

    typedef logic [AES_WORD_W-1:0] aes_word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        FINISH
    } kexp_state_t;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int aesNr(input int nk);
        return nk + 6;
    endfunction

    function automatic int aesTotalWords(input int nk);
        return 4 * (aesNr(nk) + 1);
    endfunction

endpackage

// File: rtl/aesRotateWord.sv
// RotWord datapath: cyclic one-byte left rotate, bypassable for the SubWord-only step.
module aesRotateWord
    import aes_pkg::*;
(
    input  aes_word_t wordIn,
    input  logic      disableRotate,
    output aes_word_t wordOut
);

    assign wordOut = disableRotate ? wordIn : {wordIn[23:0], wordIn[31:24]};

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  aes_word_t wordIn,
    output aes_word_t wordOut
);

    // Byte 0x00 maps from the most significant byte of this table.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    assign wordOut = {sbox(wordIn[31:24]), sbox(wordIn[23:16]),
                      sbox(wordIn[15:8]),  sbox(wordIn[7:0])};

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// AES key-schedule controller: streams w[0..TOTAL_WORDS-1] one word per valid/ready handshake.
// An NK-word window plus rcon is the only state; next-word generation is purely combinational.
module aes_key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [AES_WORD_W*NK-1:0] keyIn,
    output logic                     busy,
    output aes_word_t                wordOut,
    output logic [5:0]               wordIdx,
    output logic                     wordValid,
    input  logic                     wordReady,
    output logic                     done
);

    localparam int NR          = aesNr(NK);
    localparam int TOTAL_WORDS = aesTotalWords(NK);
    localparam int POS_W       = $clog2(NK);
    localparam logic [5:0] LAST_IDX  = 6'(TOTAL_WORDS - 1);
    localparam logic [5:0] KEY_LAST  = 6'(NK - 1);
    localparam logic [5:0] PHASE_MSK = 6'(NK - 1);

    if (NK != 4 && NK != 8) begin : gBadNk
        $error("aes_key_expand_ctrl: NK must be 4 or 8, got %0d (NR would be %0d)", NK, NR);
    end

    kexp_state_t state;
    aes_word_t   win [NK];
    logic [7:0]  rcon;

    logic [5:0]  nextIdx;
    logic [2:0]  phase;
    logic        fromKey;
    logic        accept;
    logic        disableRotate;
    aes_word_t   rotOut;
    aes_word_t   subOut;
    aes_word_t   tempWord;
    aes_word_t   nextWord;

    assign nextIdx       = wordIdx + 6'd1;
    assign phase         = 3'(nextIdx & PHASE_MSK);
    assign fromKey       = (wordIdx < KEY_LAST);
    assign accept        = (state == EMIT) && wordValid && wordReady;
    assign disableRotate = (phase != 3'd0);

    aesRotateWord uRotate (
        .wordIn        (win[NK-1]),
        .disableRotate (disableRotate),
        .wordOut       (rotOut)
    );

    aes_sub_word uSubWord (
        .wordIn  (rotOut),
        .wordOut (subOut)
    );

    // While the key words are still being emitted the window holds the raw key and is read by index.
    always_comb begin
        tempWord = win[NK-1];
        if (phase == 3'd0) begin
            tempWord = subOut ^ {rcon, 24'h0};
        end else if (NK == 8 && phase == 3'd4) begin
            tempWord = subOut;
        end
        nextWord = fromKey ? win[phase[POS_W-1:0]] : (win[0] ^ tempWord);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rcon      <= RCON_INIT;
            busy      <= 1'b0;
            wordOut   <= '0;
            wordIdx   <= '0;
            wordValid <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < NK; k++) begin
                win[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            win[k] <= keyIn[AES_WORD_W*(NK-1-k) +: AES_WORD_W];
                        end
                        rcon      <= RCON_INIT;
                        wordOut   <= keyIn[AES_WORD_W*NK-1 -: AES_WORD_W];
                        wordIdx   <= '0;
                        wordValid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (wordIdx == LAST_IDX) begin
                            wordValid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            wordOut <= nextWord;
                            wordIdx <= nextIdx;
                            if (!fromKey) begin
                                for (int k = 0; k < NK - 1; k++) begin
                                    win[k] <= win[k+1];
                                end
                                win[NK-1] <= nextWord;
                                if (phase == 3'd0) begin
                                    rcon <= xtime(rcon);
                                end
                            end
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl: FIPS-197 AES-128 and AES-256 vectors plus handshake corner cases.
module tb_aes_key_expand_ctrl;
    import aes_pkg::*;

    localparam int T128 = 44;
    localparam int T256 = 60;

    typedef struct {
        int          idx;
        logic [31:0] word;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;

    logic         start128 = 1'b0;
    logic [127:0] keyIn128 = '0;
    logic         busy128;
    logic [31:0]  wordOut128;
    logic [5:0]   wordIdx128;
    logic         wordValid128;
    logic         wordReady128 = 1'b0;
    logic         done128;

    logic         start256 = 1'b0;
    logic [255:0] keyIn256 = '0;
    logic         busy256;
    logic [31:0]  wordOut256;
    logic [5:0]   wordIdx256;
    logic         wordValid256;
    logic         wordReady256 = 1'b0;
    logic         done256;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] got128 [T128];
    logic [31:0] golden128 [T128];
    logic [31:0] got256 [T256];
    int gotCount, doneCount, doneCycle, stallErrors, idxErrors;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_W = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes_key_expand_ctrl #(.NK(4)) dut128 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start128),
        .keyIn     (keyIn128),
        .busy      (busy128),
        .wordOut   (wordOut128),
        .wordIdx   (wordIdx128),
        .wordValid (wordValid128),
        .wordReady (wordReady128),
        .done      (done128)
    );

    aes_key_expand_ctrl #(.NK(8)) dut256 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start256),
        .keyIn     (keyIn256),
        .busy      (busy256),
        .wordOut   (wordOut256),
        .wordIdx   (wordIdx256),
        .wordValid (wordValid256),
        .wordReady (wordReady256),
        .done      (done256)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    function automatic int countDiff128();
        int n = 0;
        for (int i = 0; i < T128; i++) begin
            if (got128[i] !== golden128[i]) n++;
        end
        return n;
    endfunction

    // Runs one AES-128 expansion from a negedge; returns at a negedge with the DUT back in IDLE
    // (or right after an injected reset). keyIn is scrambled after start to catch resampling.
    task automatic applyStimulus(input logic [127:0] key, input bit randomReady, input logic [127:0] altKey,
                                 input int injectStartAt, input int resetAt, input bit startOnDone);
        logic        prevStall = 1'b0;
        logic [31:0] prevWord = '0;
        logic [5:0]  prevIdx = '0;
        logic        ready;
        gotCount = 0; doneCount = 0; doneCycle = -1; stallErrors = 0; idxErrors = 0;
        keyIn128 = key;
        start128 = 1'b1;
        wordReady128 = 1'b0;
        @(negedge clk);
        keyIn128 = ~key;
        for (int cyc = 1; cyc < 400; cyc++) begin
            start128 = 1'b0;
            if (doneCycle >= 0 && cyc == doneCycle + 1) break;
            if (cyc == 1) checkOutput("busy_after_start", busy128, 1'b1);
            if (done128) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
                checkOutput("busy_low_at_done", busy128, 1'b0);
                if (startOnDone) begin
                    start128 = 1'b1;
                    keyIn128 = altKey;
                end
            end
            if (prevStall && (wordOut128 !== prevWord || wordIdx128 !== prevIdx || wordValid128 !== 1'b1))
                stallErrors++;
            if (resetAt >= 0 && wordValid128 && wordIdx128 == 6'(resetAt)) begin
                #1 rst_n = 1'b0;
                #1;
                checkOutput("rst_wordOut", wordOut128, 32'h0);
                checkOutput("rst_wordIdx", wordIdx128, 6'h0);
                checkOutput("rst_wordValid", wordValid128, 1'b0);
                checkOutput("rst_busy", busy128, 1'b0);
                @(negedge clk);
                checkOutput("rst_no_done", done128, 1'b0);
                rst_n = 1'b1;
                wordReady128 = 1'b0;
                @(negedge clk);
                checkOutput("post_rst_no_done", done128, 1'b0);
                return;
            end
            ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            wordReady128 = ready;
            if (injectStartAt >= 0 && wordValid128 && wordIdx128 == 6'(injectStartAt)) begin
                start128 = 1'b1;
                keyIn128 = altKey;
            end
            prevStall = wordValid128 && !ready;
            prevWord  = wordOut128;
            prevIdx   = wordIdx128;
            if (wordValid128 && ready) begin
                if (gotCount < T128) got128[gotCount] = wordOut128;
                if (int'(wordIdx128) != gotCount) idxErrors++;
                gotCount++;
            end
            @(negedge clk);
        end
        start128 = 1'b0;
        wordReady128 = 1'b0;
    endtask

    task automatic applyStimulusWide(input logic [255:0] key);
        gotCount = 0; doneCount = 0; doneCycle = -1; idxErrors = 0;
        keyIn256 = key;
        start256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0;
        wordReady256 = 1'b1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (doneCycle >= 0 && cyc == doneCycle + 2) break;
            if (done256) begin
                doneCount++;
                if (doneCycle < 0) doneCycle = cyc;
            end
            if (wordValid256) begin
                if (gotCount < T256) got256[gotCount] = wordOut256;
                if (int'(wordIdx256) != gotCount) idxErrors++;
                gotCount++;
            end
            @(negedge clk);
        end
        wordReady256 = 1'b0;
    endtask

    vec_t v128 [12];
    vec_t v256 [8];

    initial begin
        v128[0]  = '{0,  32'h2b7e1516};  v128[1]  = '{3,  32'h09cf4f3c};
        v128[2]  = '{4,  32'ha0fafe17};  v128[3]  = '{5,  32'h88542cb1};
        v128[4]  = '{6,  32'h23a33939};  v128[5]  = '{7,  32'h2a6c7605};
        v128[6]  = '{40, 32'hd014f9a8};  v128[7]  = '{41, 32'hc9ee2589};
        v128[8]  = '{42, 32'he13f0cc8};  v128[9]  = '{43, 32'hb6630ca6};
        v128[10] = '{1,  32'h28aed2a6};  v128[11] = '{2,  32'habf71588};
        v256[0]  = '{0,  32'h603deb10};  v256[1]  = '{7,  32'h0914dff4};
        v256[2]  = '{8,  32'h9ba35411};  v256[3]  = '{9,  32'h8e6925af};
        v256[4]  = '{12, 32'ha8b09c1a};  v256[5]  = '{13, 32'h93d194cd};
        v256[6]  = '{59, 32'h706c631e};  v256[7]  = '{4,  32'h1f352c07};

        #2 rst_n = 1'b0;
        #3;
        checkOutput("reset_wordValid", wordValid128, 1'b0);
        checkOutput("reset_busy", busy128, 1'b0);
        checkOutput("reset_done", done128, 1'b0);
        checkOutput("reset_wordOut", wordOut128, 32'h0);
        checkOutput("reset_busy256", busy256, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] AES-128 zero-stall run, start during done pulse");
        applyStimulus(KEY_A, 1'b0, KEY_B, -1, -1, 1'b1);
        checkOutput("done_latency", doneCycle, 45);
        checkOutput("done_count", doneCount, 1);
        checkOutput("word_count", gotCount, T128);
        checkOutput("idx_sequence", idxErrors, 0);
        checkOutput("start_on_done_ignored_valid", wordValid128, 1'b0);
        checkOutput("start_on_done_ignored_busy", busy128, 1'b0);
        foreach (v128[k]) begin
            checkOutput($sformatf("aes128_w%0d", v128[k].idx), got128[v128[k].idx], v128[k].word);
        end
        foreach (got128[i]) golden128[i] = got128[i];

        $display("[TB] AES-128 back-to-back start in the cycle after done");
        applyStimulus(KEY_A, 1'b0, KEY_B, -1, -1, 1'b0);
        checkOutput("b2b_done_latency", doneCycle, 45);
        checkOutput("b2b_stream_diff", countDiff128(), 0);

        $display("[TB] AES-128 random backpressure");
        applyStimulus(KEY_A, 1'b1, KEY_B, -1, -1, 1'b0);
        checkOutput("bp_word_count", gotCount, T128);
        checkOutput("bp_done_count", doneCount, 1);
        checkOutput("bp_stall_stable", stallErrors, 0);
        checkOutput("bp_idx_sequence", idxErrors, 0);
        checkOutput("bp_stream_diff", countDiff128(), 0);

        $display("[TB] AES-128 start while busy");
        applyStimulus(KEY_A, 1'b0, KEY_B, 10, -1, 1'b0);
        checkOutput("busy_start_done_count", doneCount, 1);
        checkOutput("busy_start_stream_diff", countDiff128(), 0);

        $display("[TB] AES-128 reset mid-expansion then new key");
        applyStimulus(KEY_A, 1'b0, KEY_B, -1, 20, 1'b0);
        checkOutput("aborted_done_count", doneCount, 0);
        applyStimulus(KEY_B, 1'b0, KEY_A, -1, -1, 1'b0);
        checkOutput("after_rst_w0", got128[0], 32'h00010203);
        checkOutput("after_rst_w4", got128[4], 32'hd6aa74fd);
        checkOutput("after_rst_done_count", doneCount, 1);

        $display("[TB] AES-256 zero-stall run");
        applyStimulusWide(KEY_W);
        checkOutput("aes256_word_count", gotCount, T256);
        checkOutput("aes256_done_count", doneCount, 1);
        checkOutput("aes256_idx_sequence", idxErrors, 0);
        foreach (v256[k]) begin
            checkOutput($sformatf("aes256_w%0d", v256[k].idx), got256[v256[k].idx], v256[k].word);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_ctrl.md
Name: aes_key_expand_ctrl

Overview:
- Sequential AES key-schedule controller. Expands a cipher key into the full round-key word stream, one 32-bit word per accepted handshake.
- Drives the existing aesRotateWord datapath, using its disableRotate input for the AES-256 SubWord-only step. Also drives a SubWord S-box stage.
- Sits between the key register file and the round-key store that feeds the cipher rounds.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4 (AES-128) and 8 (AES-256); any other value is a elaboration error.
- NR, NK+6, round count, derived; not overridable.
- TOTAL_WORDS, 4*(NR+1), words emitted per expansion (44 or 60), derived.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin expansion; ignored while busy.
- keyIn  in  32*NK  cipher key; word 0 is in the MSBs; sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- wordOut  out  32  current round-key word; byte a0 is in bits [31:24].
- wordIdx  out  6  index i of wordOut, from 0 to TOTAL_WORDS-1.
- wordValid  out  1  wordOut/wordIdx hold a valid word.
- wordReady  in  1  consumer accepts the word when wordValid && wordReady.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset is asynchronous on rst_n low. Every output goes to 0, the FSM goes to IDLE, the NK-word window clears, and rcon is set to 0x01. Reset asserted mid-expansion aborts the expansion with no done pulse.
- FSM states: IDLE, EMIT, FINISH.
- IDLE: start=1 latches keyIn into the window, sets wordOut=w0, wordIdx=0, wordValid=1, busy=1, and moves to EMIT. First word appears 1 cycle after start.
- EMIT, handshake:
  - On wordValid && wordReady, the next word w[i+1] is registered onto wordOut the following edge. Zero-bubble throughput is 1 word/cycle.
  - With wordReady=0, wordOut, wordIdx and wordValid hold stable. wordValid never drops until the word is accepted.
- Word generation for i < NK: w[i] = key word i.
- Word generation for i >= NK: w[i] = w[i-NK] ^ temp, with temp chosen as follows:
  - i mod NK == 0: temp = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}. After this use, rcon <= xtime(rcon), i.e. 0x80 -> 0x1b, 0x1b -> 0x36.
  - NK==8 and i mod 8 == 4: temp = SubWord(w[i-1]), with rotate disabled and no rcon.
  - Otherwise: temp = w[i-1].
- Window: NK-word shift register holding w[i-NK..i-1], shifted on each accept. Generation is purely combinational from the window and rcon; no extra pipeline stage.
- Last word: accepting wordIdx == TOTAL_WORDS-1 moves the FSM to FINISH, clears wordValid, and pulses done=1 for one cycle. busy falls in the same cycle. The FSM then returns to IDLE.
- start asserted in EMIT or FINISH is ignored, with no side effects. start in the same cycle as the done pulse is also ignored; a new start is accepted from IDLE only.
- wordReady while wordValid=0 has no effect.

Decomposition:
- Shared package aes_pkg holds:
  - AES_WORD_W=32;
  - typedef aes_word_t;
  - the RCON_INIT=8'h01 constant;
  - an xtime function;
  - NR/TOTAL_WORDS helper functions of NK.
- One natural sub-module, aes_sub_word: combinational, 4 parallel S-box byte lookups, 32-bit in/out. Instantiated once, fed by aesRotateWord.
- The FSM and window stay in this module.

Test Plan:
- AES-128 FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c with wordReady=1:
  - w0=2b7e1516; w4=a0fafe17; w40=d014f9a8 (rcon 0x36); w43=b6630ca6;
  - done pulses 45 cycles after start; 44 words on consecutive cycles.
- AES-256 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - w8=9ba35411; w12=a8b09c1a (SubWord-only path); w59=706c631e;
  - exactly 60 words emitted.
- Random wordReady backpressure (≈50%) on the AES-128 key:
  - the word sequence is identical to the zero-stall run;
  - wordOut/wordIdx are stable in every stalled cycle;
  - exactly one done pulse.
- start pulsed again at wordIdx=10 with a different key: ignored; the output stream still matches the original key's w11..w43.
- rst_n low at wordIdx=20:
  - all outputs are 0 immediately, asynchronously; no done pulse.
  - A new start after release yields w0 of the new key and rcon restarting at 0x01 (w4 correct).
- Back-to-back start in the cycle after done: accepted from IDLE; the second expansion is bit-identical to the first.
